life_gen_engine: RTL and testbench
==================================

LIFE_GEN_ENGINE -- requirements
Module: life_gen_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: grid columns, range 3..64.
REQ-002 SHALL have parameter HEIGHT, default 8: grid rows, range 3..64.
REQ-003 SHALL have parameter WRAP, default 1: 1 = toroidal edges, 0 = cells outside the grid count as dead.
REQ-004 SHALL have ports (N = WIDTH*HEIGHT), clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  load grid_in into the grid.
- grid_in  in  N  new grid; bit index = y*WIDTH + x.
- start  in  1  begin a run.
- num_gens  in  8  generations to run.
- birth_mask  in  9  bit k set: a dead cell with k live neighbours is born.
- survive_mask  in  9  bit k set: a live cell with k live neighbours survives.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- grid_out  out  N  current committed grid.
- gen_count  out  16  generations committed since last load.

Function
REQ-005 SHALL implement FSM states IDLE, SCAN, COMMIT.
REQ-006 In IDLE, load=1 SHALL copy grid_in to grid_out and clear gen_count at that edge.
REQ-007 In IDLE with load=0 and start=1, SHALL latch num_gens, birth_mask and survive_mask; if num_gens=0, SHALL pulse done next cycle and stay IDLE; otherwise SHALL enter SCAN with cell index 0 and set busy=1.
REQ-008 If load and start are both high in IDLE, load SHALL take effect and start SHALL be ignored.
REQ-009 load, start and all mask/num_gens changes SHALL be ignored outside IDLE; the latched copies SHALL be used for the whole run.
REQ-010 SCAN SHALL evaluate exactly one cell per clock in ascending index order; the cell's result SHALL be written to a shadow grid, and neighbours SHALL be read only from grid_out.
REQ-011 Neighbour count SHALL be the sum of the 8 Moore neighbours, range 0..8, 4 bits, with no overflow.
REQ-012 With WRAP=1, x-1 at x=0 SHALL map to WIDTH-1, x+1 at WIDTH-1 SHALL map to 0, and the same for y with HEIGHT; non-power-of-2 sizes SHALL be supported.
REQ-013 With WRAP=0, neighbours with x or y outside the grid SHALL contribute 0.
REQ-014 Next state SHALL be survive_mask[count] for a live cell and birth_mask[count] for a dead cell.
REQ-015 After index N-1, SHALL go to COMMIT; COMMIT SHALL copy the shadow grid to grid_out and increment gen_count, wrapping at 16 bits, in one edge.
REQ-016 After COMMIT, if the remaining count > 0, SHALL return to SCAN at index 0; else SHALL go to IDLE with busy=0 and done=1 for exactly one cycle.
REQ-017 Each generation SHALL take N+1 cycles; a run started at edge E0 SHALL show the final grid and done=1 after edge E0 + num_gens*(N+1).
REQ-018 grid_out SHALL change only at load or COMMIT edges; it SHALL never show a partially updated grid.

Reset
REQ-019 rst_n=0 SHALL immediately force state to IDLE, grid_out to 0, the shadow grid to 0, gen_count to 0, busy to 0, done to 0, and clear the latched masks and count, without waiting for clk.
REQ-020 Reset during SCAN or COMMIT SHALL abandon the run; the first edge after release SHALL see IDLE.

Verification
REQ-021 Blinker, 8x8, WRAP=1, B=9'h008, S=9'h00C: load bits {26,27,28}, start num_gens=1 -> done after 65 cycles, grid_out={19,27,35}, gen_count=1.
REQ-022 Glider on 8x8 torus, Conway rules, num_gens=32 -> grid_out equals loaded pattern, gen_count=32, done high exactly once, busy high for 32*65 cycles.
REQ-023 WRAP=0 vs WRAP=1, 8x8: load corner block {0,7,56,63} -> WRAP=1 stays unchanged after 1 gen (2x2 block across wrap); WRAP=0 gives all-zero grid.
REQ-024 num_gens=0 -> done pulses next cycle, busy never high, grid_out and gen_count unchanged; load pulsed while busy -> ignored.
REQ-025 Assert rst_n=0 mid-SCAN (index 30) -> outputs 0 without a clock edge; after release, load plus a new start run completes normally.
REQ-026 Non-square 5x7, WRAP=1, HighLife (B=9'h048, S=9'h00C): compare grid_out after 10 gens against a reference model -> exact match.

Source files
------------

// File: rtl/life_gen_engine.sv
// life_gen_engine: cellular-automaton generation engine. A committed grid is
// scanned one cell per clock into a shadow grid using latched birth/survive
// masks, then the shadow is committed in a single edge, so grid_out never
// shows a half-updated generation.
module life_gen_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [WIDTH*HEIGHT-1:0] grid_in,
    input  logic                    start,
    input  logic [7:0]              num_gens,
    input  logic [8:0]              birth_mask,
    input  logic [8:0]              survive_mask,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*HEIGHT-1:0] grid_out,
    output logic [15:0]             gen_count
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_grid;
    logic [N-1:0]  r_shadow;
    logic [15:0]   r_gen_count;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_remain;
    logic [8:0]    r_birth;
    logic [8:0]    r_survive;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    logic [XW-1:0] w_xm, w_xp;
    logic [YW-1:0] w_ym, w_yp;
    logic          w_xm_ok, w_xp_ok, w_ym_ok, w_yp_ok;
    logic [IW-1:0] w_cidx;
    logic [3:0]    w_cnt;
    logic          w_self;
    logic          w_next;

    // Reads one neighbour from the committed grid; out-of-grid positions read as dead
    function automatic logic cellAt(input logic [N-1:0] g, input logic [YW-1:0] yy,
                                    input logic [XW-1:0] xx, input logic ok);
        logic [IW-1:0] idx;
        idx = IW'(yy) * IW'(WIDTH) + IW'(xx);
        return ok & g[idx];
    endfunction

    // Neighbour coordinates: wrap around the torus, or flag the edge as empty
    always_comb begin
        w_xm    = (r_x == '0) ? XW'(WIDTH - 1) : r_x - XW'(1);
        w_xp    = (r_x == XW'(WIDTH - 1)) ? '0 : r_x + XW'(1);
        w_ym    = (r_y == '0) ? YW'(HEIGHT - 1) : r_y - YW'(1);
        w_yp    = (r_y == YW'(HEIGHT - 1)) ? '0 : r_y + YW'(1);
        w_xm_ok = (WRAP != 0) || (r_x != '0);
        w_xp_ok = (WRAP != 0) || (r_x != XW'(WIDTH - 1));
        w_ym_ok = (WRAP != 0) || (r_y != '0);
        w_yp_ok = (WRAP != 0) || (r_y != YW'(HEIGHT - 1));
    end

    // Count the 8 Moore neighbours of the current cell and pick its next state
    always_comb begin
        w_cidx = IW'(r_y) * IW'(WIDTH) + IW'(r_x);
        w_self = r_grid[w_cidx];
        w_cnt  = {3'b000, cellAt(r_grid, w_ym, w_xm, w_ym_ok & w_xm_ok)}
               + {3'b000, cellAt(r_grid, w_ym, r_x,  w_ym_ok)}
               + {3'b000, cellAt(r_grid, w_ym, w_xp, w_ym_ok & w_xp_ok)}
               + {3'b000, cellAt(r_grid, r_y,  w_xm, w_xm_ok)}
               + {3'b000, cellAt(r_grid, r_y,  w_xp, w_xp_ok)}
               + {3'b000, cellAt(r_grid, w_yp, w_xm, w_yp_ok & w_xm_ok)}
               + {3'b000, cellAt(r_grid, w_yp, r_x,  w_yp_ok)}
               + {3'b000, cellAt(r_grid, w_yp, w_xp, w_yp_ok & w_xp_ok)};
        w_next = w_self ? r_survive[w_cnt] : r_birth[w_cnt];
    end

    // Control FSM, scan position, shadow grid and committed grid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grid      <= '0;
            r_shadow    <= '0;
            r_gen_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remain    <= '0;
            r_birth     <= '0;
            r_survive   <= '0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_grid      <= grid_in;
                        r_gen_count <= '0;
                    end else if (start) begin
                        r_remain  <= num_gens;
                        r_birth   <= birth_mask;
                        r_survive <= survive_mask;
                        if (num_gens == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                            r_x     <= '0;
                            r_y     <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    r_shadow[w_cidx] <= w_next;
                    if (r_x == XW'(WIDTH - 1)) begin
                        r_x <= '0;
                        if (r_y == YW'(HEIGHT - 1)) begin
                            r_y     <= '0;
                            r_state <= S_COMMIT;
                        end else begin
                            r_y <= r_y + YW'(1);
                        end
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
                S_COMMIT: begin
                    r_grid      <= r_shadow;
                    r_gen_count <= r_gen_count + 16'd1;
                    if (r_remain == 8'd1) begin
                        r_remain <= '0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_remain <= r_remain - 8'd1;
                        r_state  <= S_SCAN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign grid_out  = r_grid;
    assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: scoreboard bench for life_gen_engine. Three instances:
// 8x8 torus (A), 8x8 bounded (B, shares A's stimulus) and 5x7 torus (C).
module tb_life_gen_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        loadAB, startAB, loadC, startC;
    logic [7:0]  numGens;
    logic [8:0]  bMask, sMask;
    logic [63:0] gridInAB;
    logic [34:0] gridInC;

    logic        busyA, doneA, busyB, doneB, busyC, doneC;
    logic [63:0] gridOutA, gridOutB;
    logic [34:0] gridOutC;
    logic [15:0] genA, genB, genC;

    life_gen_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(1)) dutA (
        .clk(clk), .rst_n(rst_n), .load(loadAB), .grid_in(gridInAB), .start(startAB),
        .num_gens(numGens), .birth_mask(bMask), .survive_mask(sMask),
        .busy(busyA), .done(doneA), .grid_out(gridOutA), .gen_count(genA));

    life_gen_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(0)) dutB (
        .clk(clk), .rst_n(rst_n), .load(loadAB), .grid_in(gridInAB), .start(startAB),
        .num_gens(numGens), .birth_mask(bMask), .survive_mask(sMask),
        .busy(busyB), .done(doneB), .grid_out(gridOutB), .gen_count(genB));

    life_gen_engine #(.WIDTH(5), .HEIGHT(7), .WRAP(1)) dutC (
        .clk(clk), .rst_n(rst_n), .load(loadC), .grid_in(gridInC), .start(startC),
        .num_gens(numGens), .birth_mask(bMask), .survive_mask(sMask),
        .busy(busyC), .done(doneC), .grid_out(gridOutC), .gen_count(genC));

    typedef struct {
        bit          sel;
        logic [63:0] gridA;
        logic [63:0] gridB;
        logic [15:0] gens;
        int          lat;
    } expT;

    expT         expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          disturbAt = -1;
    logic [63:0] mdlA, mdlB, mdlC;
    logic [15:0] mdlGenAB, mdlGenC;

    // Reference model: one generation on a w x h grid, bit index y*w+x
    function automatic logic [63:0] lifeStep(input logic [63:0] g, input int w, input int h,
                                             input bit wrap, input logic [8:0] bm,
                                             input logic [8:0] sm);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                int cnt;
                logic [5:0] here;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        logic [5:0] nIdx;
                        nx = x + dx;
                        ny = y + dy;
                        if (dx == 0 && dy == 0) continue;
                        if (wrap) begin
                            nx = (nx + w) % w;
                            ny = (ny + h) % h;
                        end else if (nx < 0 || nx >= w || ny < 0 || ny >= h) begin
                            continue;
                        end
                        nIdx = 6'(ny * w + nx);
                        if (g[nIdx]) cnt++;
                    end
                end
                here = 6'(y * w + x);
                r[here] = g[here] ? sm[4'(cnt)] : bm[4'(cnt)];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a grid with start held high too: load must win and no run may begin
    task automatic loadGrid(input bit sel, input logic [63:0] g);
        @(negedge clk);
        numGens = 8'd1;
        if (sel) begin
            gridInC = g[34:0];
            loadC = 1'b1;
            startC = 1'b1;
        end else begin
            gridInAB = g;
            loadAB = 1'b1;
            startAB = 1'b1;
        end
        @(negedge clk);
        loadAB = 1'b0; startAB = 1'b0; loadC = 1'b0; startC = 1'b0;
        if (sel) begin
            mdlC = g;
            mdlGenC = '0;
            checkOutput("loadGridC", {29'b0, gridOutC}, g);
            checkOutput("loadGenC", 64'(genC), 64'd0);
            checkOutput("loadBusyC", 64'(busyC), 64'd0);
        end else begin
            mdlA = g;
            mdlB = g;
            mdlGenAB = '0;
            checkOutput("loadGridA", gridOutA, g);
            checkOutput("loadGridB", gridOutB, g);
            checkOutput("loadGenA", 64'(genA), 64'd0);
            checkOutput("loadBusyA", 64'(busyA), 64'd0);
        end
    endtask

    // Pulse start for one edge; optionally push the model's expectation
    task automatic applyStimulus(input bit sel, input logic [7:0] n, input logic [8:0] b,
                                 input logic [8:0] s, input bit push);
        expT e;
        @(negedge clk);
        numGens = n;
        bMask = b;
        sMask = s;
        if (sel) startC = 1'b1;
        else startAB = 1'b1;
        if (push) begin
            e.sel = sel;
            if (sel) begin
                for (int i = 0; i < int'(n); i++) mdlC = lifeStep(mdlC, 5, 7, 1'b1, b, s);
                mdlGenC = mdlGenC + 16'(n);
                e.gridA = mdlC;
                e.gridB = '0;
                e.gens = mdlGenC;
                e.lat = int'(n) * 36;
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    mdlA = lifeStep(mdlA, 8, 8, 1'b1, b, s);
                    mdlB = lifeStep(mdlB, 8, 8, 1'b0, b, s);
                end
                mdlGenAB = mdlGenAB + 16'(n);
                e.gridA = mdlA;
                e.gridB = mdlB;
                e.gens = mdlGenAB;
                e.lat = int'(n) * 65;
            end
            expQ.push_back(e);
        end
        @(negedge clk);
        startAB = 1'b0;
        startC = 1'b0;
    endtask

    // Wait for done, then pop the expectation and compare grid, count and timing
    task automatic waitDone(input bit sel);
        int  lat;
        int  busyCnt;
        expT e;
        lat = 0;
        busyCnt = 0;
        while (((sel ? doneC : doneA) == 1'b0) && lat < 5000) begin
            if (sel ? busyC : busyA) busyCnt++;
            if (lat == disturbAt) begin
                gridInAB = '1; gridInC = '1;
                if (sel) begin loadC = 1'b1; startC = 1'b1; end
                else begin loadAB = 1'b1; startAB = 1'b1; end
                numGens = 8'd5; bMask = '1; sMask = '1;
            end
            if (lat == disturbAt + 1) begin
                loadAB = 1'b0; startAB = 1'b0; loadC = 1'b0; startC = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        disturbAt = -1;
        checkOutput("doneSeen", 64'(sel ? doneC : doneA), 64'd1);
        checkOutput("sbDepth", 64'(expQ.size()), 64'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (sel) begin
                checkOutput("gridC", {29'b0, gridOutC}, e.gridA);
                checkOutput("genC", 64'(genC), 64'(e.gens));
            end else begin
                checkOutput("gridA", gridOutA, e.gridA);
                checkOutput("gridB", gridOutB, e.gridB);
                checkOutput("genA", 64'(genA), 64'(e.gens));
            end
            checkOutput("latency", 64'(lat), 64'(e.lat));
            checkOutput("busyCycles", 64'(busyCnt), 64'(e.lat));
        end
        checkOutput("busyAtDone", 64'(sel ? busyC : busyA), 64'd0);
        @(negedge clk);
        checkOutput("donePulse", 64'(sel ? doneC : doneA), 64'd0);
    endtask

    logic [63:0] g;
    logic [63:0] rnd;

    initial begin
        rst_n = 1'b0;
        loadAB = 1'b0; startAB = 1'b0; loadC = 1'b0; startC = 1'b0;
        numGens = '0; bMask = '0; sMask = '0; gridInAB = '0; gridInC = '0;
        mdlA = '0; mdlB = '0; mdlC = '0; mdlGenAB = '0; mdlGenC = '0;
        #12;
        checkOutput("rstGridA", gridOutA, 64'd0);
        checkOutput("rstGenA", 64'(genA), 64'd0);
        checkOutput("rstBusyA", 64'(busyA), 64'd0);
        checkOutput("rstDoneA", 64'(doneA), 64'd0);
        checkOutput("rstGridC", {29'b0, gridOutC}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] blinker");
        g = '0; g[26] = 1'b1; g[27] = 1'b1; g[28] = 1'b1;
        loadGrid(1'b0, g);
        applyStimulus(1'b0, 8'd1, 9'h008, 9'h00C, 1'b1);
        waitDone(1'b0);
        g = '0; g[19] = 1'b1; g[27] = 1'b1; g[35] = 1'b1;
        checkOutput("blinkerVertical", gridOutA, g);

        $display("[TB] corner block");
        g = '0; g[0] = 1'b1; g[7] = 1'b1; g[56] = 1'b1; g[63] = 1'b1;
        loadGrid(1'b0, g);
        applyStimulus(1'b0, 8'd1, 9'h008, 9'h00C, 1'b1);
        waitDone(1'b0);
        checkOutput("cornerWrap", gridOutA, g);
        checkOutput("cornerNoWrap", gridOutB, 64'd0);

        $display("[TB] zero generations");
        applyStimulus(1'b0, 8'd0, 9'h008, 9'h00C, 1'b1);
        waitDone(1'b0);

        $display("[TB] glider 32 generations with ignored load/start mid-run");
        g = '0; g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
        loadGrid(1'b0, g);
        disturbAt = 100;
        applyStimulus(1'b0, 8'd32, 9'h008, 9'h00C, 1'b1);
        waitDone(1'b0);
        checkOutput("gliderHome", gridOutA, g);
        checkOutput("gliderGen", 64'(genA), 64'd32);

        $display("[TB] reset mid-scan");
        applyStimulus(1'b0, 8'd2, 9'h008, 9'h00C, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("busyBeforeRst", 64'(busyA), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncGridA", gridOutA, 64'd0);
        checkOutput("asyncGenA", 64'(genA), 64'd0);
        checkOutput("asyncBusyA", 64'(busyA), 64'd0);
        checkOutput("asyncDoneA", 64'(doneA), 64'd0);
        checkOutput("asyncGridB", gridOutB, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdlA = '0; mdlB = '0; mdlC = '0; mdlGenAB = '0; mdlGenC = '0;
        g = '0; g[26] = 1'b1; g[27] = 1'b1; g[28] = 1'b1;
        loadGrid(1'b0, g);
        applyStimulus(1'b0, 8'd1, 9'h008, 9'h00C, 1'b1);
        waitDone(1'b0);

        $display("[TB] 5x7 HighLife 10 generations");
        rnd = {$urandom(), $urandom()};
        rnd = rnd & 64'h7_FFFF_FFFF;
        loadGrid(1'b1, rnd);
        applyStimulus(1'b1, 8'd10, 9'h048, 9'h00C, 1'b1);
        waitDone(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
